// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - key/mode controller for the multi-mode clock
//
// Purpose:
//   Synchronises the four push-buttons, detects press edges and sequences
//   the view/edit modes (clock, time-set, stopwatch, alarm). Emits one-cycle
//   one-hot adjust pulses to the clock and alarm counters, the display
//   source select, the flash mask and the stopwatch run flag.
//
// Optional feature: CLOCK_MODE_CTRL_AUTO_REPEAT_EN (auto-repeat of held
//   inc/dec keys). The default build (macro undefined) has no repeat logic.
//
// Ports:
//   clk_out    in   1  block clock
//   top_rst    in   1  asynchronous, active-high reset
//   key_n      in   4  raw buttons, active-low: [0] mode, [1] select/run, [2] inc, [3] dec
//   alarming   in   1  alarm currently ringing
//   mode       out  2  0 clock, 1 time-set, 2 stopwatch, 3 alarm
//   flash      out  3  one-hot field being edited {hour,min,sec}
//   clock_inc  out  3  one-cycle increment pulse to clock
//   clock_dec  out  3  one-cycle decrement pulse to clock
//   alarm_inc  out  3  one-cycle increment pulse to alarm setting
//   alarm_dec  out  3  one-cycle decrement pulse to alarm setting
//   sw_run     out  1  stopwatch run enable
//   alarm_ack  out  1  one-cycle pulse: silence alarm
module clock_mode_ctrl #(
  parameter int IDLE_TIMEOUT = 16
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
`endif
) (
  input  logic       clk_out,
  input  logic       top_rst,
  input  logic [3:0] key_n,
  input  logic       alarming,
  output logic [1:0] mode,
  output logic [2:0] flash,
  output logic [2:0] clock_inc,
  output logic [2:0] clock_dec,
  output logic [2:0] alarm_inc,
  output logic [2:0] alarm_dec,
  output logic       sw_run,
  output logic       alarm_ack
);

  typedef enum logic [3:0] {
    CLK_VIEW = 4'd0,
    TS_IDLE  = 4'd1,
    TS_HOUR  = 4'd2,
    TS_MIN   = 4'd3,
    TS_SEC   = 4'd4,
    SW_VIEW  = 4'd5,
    AL_IDLE  = 4'd6,
    AL_HOUR  = 4'd7,
    AL_MIN   = 4'd8,
    AL_SEC   = 4'd9
  } state_t;

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT);

  state_t        state, state_nxt;
  logic [3:0]    sync1, sync2, sync3;
  logic [3:0]    press;
  logic          any_press;
  logic [CW-1:0] idle_cnt, idle_nxt;
  logic          sw_run_nxt, ack_nxt;
  logic [2:0]    cinc_nxt, cdec_nxt, ainc_nxt, adec_nxt;
  logic          adj_fire, adj_dec;
  logic [2:0]    cur_field;

  // Keys are active-low: a press is sync2 newly low while sync3 is still high.
  assign press     = sync3 & ~sync2;
  assign any_press = |press;

  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      TS_HOUR, AL_HOUR: field_of = 3'b100;
      TS_MIN,  AL_MIN:  field_of = 3'b010;
      TS_SEC,  AL_SEC:  field_of = 3'b001;
      default:          field_of = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      TS_IDLE, TS_HOUR, TS_MIN, TS_SEC: mode_of = 2'd1;
      SW_VIEW:                          mode_of = 2'd2;
      AL_IDLE, AL_HOUR, AL_MIN, AL_SEC: mode_of = 2'd3;
      default:                          mode_of = 2'd0;
    endcase
  endfunction

  // Edit states are the ones subject to the idle timeout.
  function automatic logic is_edit(input state_t s);
    case (s)
      TS_IDLE, TS_HOUR, TS_MIN, TS_SEC,
      AL_IDLE, AL_HOUR, AL_MIN, AL_SEC: is_edit = 1'b1;
      default:                          is_edit = 1'b0;
    endcase
  endfunction

  assign cur_field = field_of(state);

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic          rep_active, rep_active_nxt;
  logic          rep_dec, rep_dec_nxt;
  logic          rep_first, rep_first_nxt;
  logic [RW-1:0] rep_cnt, rep_cnt_nxt;
  logic          rep_hold, rep_fire, adj_press;

  // Repeat continues only while the same single key stays down in the same
  // edit field with no other press and no ringing alarm.
  assign rep_hold = rep_active && (cur_field != 3'b000) && !alarming && !any_press &&
                    (rep_dec ? (sync2[2] & ~sync2[3]) : (~sync2[2] & sync2[3]));
  assign rep_fire = rep_hold && (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST));
`endif

  always_comb begin
    state_nxt  = state;
    sw_run_nxt = sw_run;
    ack_nxt    = 1'b0;
    cinc_nxt   = 3'b000;
    cdec_nxt   = 3'b000;
    ainc_nxt   = 3'b000;
    adec_nxt   = 3'b000;
    adj_fire   = 1'b0;
    adj_dec    = 1'b0;
    idle_nxt   = idle_cnt;
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
    adj_press  = 1'b0;
`endif

    if (state > AL_SEC) begin
      state_nxt = CLK_VIEW;
    end else if (alarming && any_press) begin
      // A press while ringing only silences the alarm.
      ack_nxt = 1'b1;
    end else if (press[0]) begin
      case (state)
        CLK_VIEW:                         state_nxt = TS_IDLE;
        TS_IDLE, TS_HOUR, TS_MIN, TS_SEC: state_nxt = SW_VIEW;
        SW_VIEW:                          state_nxt = AL_IDLE;
        default:                          state_nxt = CLK_VIEW;
      endcase
    end else if (press[1]) begin
      case (state)
        TS_IDLE, TS_SEC: state_nxt = TS_HOUR;
        TS_HOUR:         state_nxt = TS_MIN;
        TS_MIN:          state_nxt = TS_SEC;
        AL_IDLE, AL_SEC: state_nxt = AL_HOUR;
        AL_HOUR:         state_nxt = AL_MIN;
        AL_MIN:          state_nxt = AL_SEC;
        SW_VIEW:         sw_run_nxt = ~sw_run;
        default:         ;
      endcase
    end else if (press[2] ^ press[3]) begin
      adj_fire = 1'b1;
      adj_dec  = press[3];
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
      adj_press = 1'b1;
`endif
    end
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
    else if (rep_fire) begin
      adj_fire = 1'b1;
      adj_dec  = rep_dec;
    end
`endif
    else if (!any_press && is_edit(state) && idle_cnt == IDLE_LAST) begin
      state_nxt = CLK_VIEW;
    end

    // The field mask is zero outside edit fields, so ignored presses emit nothing.
    if (adj_fire) begin
      if (mode_of(state) == 2'd1) begin
        if (adj_dec) cdec_nxt = cur_field;
        else         cinc_nxt = cur_field;
      end else if (mode_of(state) == 2'd3) begin
        if (adj_dec) adec_nxt = cur_field;
        else         ainc_nxt = cur_field;
      end
    end

    if (any_press || state_nxt != state) begin
      idle_nxt = '0;
    end
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
    else if (rep_hold) begin
      idle_nxt = '0;
    end
`endif
    else if (idle_cnt != IDLE_LAST) begin
      idle_nxt = idle_cnt + 1'b1;
    end
  end

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  always_comb begin
    rep_active_nxt = 1'b0;
    rep_dec_nxt    = rep_dec;
    rep_first_nxt  = rep_first;
    rep_cnt_nxt    = '0;
    if (adj_press && cur_field != 3'b000) begin
      rep_active_nxt = 1'b1;
      rep_dec_nxt    = press[3];
      rep_first_nxt  = 1'b1;
    end else if (rep_hold) begin
      rep_active_nxt = 1'b1;
      if (rep_fire) begin
        rep_first_nxt = 1'b0;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_out or posedge top_rst) begin
    if (top_rst) begin
      rep_active <= 1'b0;
      rep_dec    <= 1'b0;
      rep_first  <= 1'b0;
      rep_cnt    <= '0;
    end else begin
      rep_active <= rep_active_nxt;
      rep_dec    <= rep_dec_nxt;
      rep_first  <= rep_first_nxt;
      rep_cnt    <= rep_cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk_out or posedge top_rst) begin
    if (top_rst) begin
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      sync3     <= 4'hF;
      state     <= CLK_VIEW;
      idle_cnt  <= '0;
      mode      <= 2'd0;
      flash     <= 3'b000;
      clock_inc <= 3'b000;
      clock_dec <= 3'b000;
      alarm_inc <= 3'b000;
      alarm_dec <= 3'b000;
      sw_run    <= 1'b0;
      alarm_ack <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      sync3     <= sync2;
      state     <= state_nxt;
      idle_cnt  <= idle_nxt;
      // Registered decode of the next state keeps mode/flash glitch-free.
      mode      <= mode_of(state_nxt);
      flash     <= field_of(state_nxt);
      clock_inc <= cinc_nxt;
      clock_dec <= cdec_nxt;
      alarm_inc <= ainc_nxt;
      alarm_dec <= adec_nxt;
      sw_run    <= sw_run_nxt;
      alarm_ack <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - scoreboard bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

  logic       clk_out = 1'b0;
  logic       top_rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       alarming = 1'b0;
  logic [1:0] mode;
  logic [2:0] flash, clock_inc, clock_dec, alarm_inc, alarm_dec;
  logic       sw_run, alarm_ack;

  clock_mode_ctrl dut (
    .clk_out   (clk_out),
    .top_rst   (top_rst),
    .key_n     (key_n),
    .alarming  (alarming),
    .mode      (mode),
    .flash     (flash),
    .clock_inc (clock_inc),
    .clock_dec (clock_dec),
    .alarm_inc (alarm_inc),
    .alarm_dec (alarm_dec),
    .sw_run    (sw_run),
    .alarm_ack (alarm_ack)
  );

  always #5 clk_out = ~clk_out;

  int cyc = 0;
  always @(posedge clk_out) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] v;
    int          at;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   last_c = 0;
  logic sw = 1'b0;

  wire [19:0] dut_snap = {mode, flash, clock_inc, clock_dec, alarm_inc, alarm_dec, sw_run, alarm_ack};

  localparam logic [11:0] NP  = 12'b000_000_000_000;
  localparam logic [11:0] CI4 = 12'b100_000_000_000;
  localparam logic [11:0] CD2 = 12'b000_010_000_000;
  localparam logic [11:0] AI1 = 12'b000_000_001_000;
  localparam logic [11:0] AD1 = 12'b000_000_000_001;

  function automatic logic [19:0] s(input logic [1:0] m, input logic [2:0] f,
                                    input logic [11:0] p, input logic swr, input logic ack);
    s = {m, f, p, swr, ack};
  endfunction

  task automatic push(input logic [19:0] v, input int at);
    exp_t e;
    e.v  = v;
    e.at = at;
    q.push_back(e);
  endtask

  // Press keys k for one sampled edge; expect n output changes at c+3 and c+4.
  task automatic hit(input logic [3:0] k, input int n, input logic [19:0] e0, input logic [19:0] e1);
    @(negedge clk_out);
    key_n  = ~k;
    last_c = cyc;
    if (n > 0) push(e0, last_c + 3);
    if (n > 1) push(e1, last_c + 4);
    @(negedge clk_out);
    key_n = 4'hF;
    repeat (4) @(negedge clk_out);
  endtask

  // Monitor: every change of the output bundle is one presented response.
  initial begin : monitor
    logic [19:0] prev, cur;
    exp_t e;
    bit first;
    first = 1'b1;
    prev  = '0;
    wait (mon_en);
    forever begin
      @(negedge clk_out);
      cur = dut_snap;
      if (first || cur !== prev) begin
        first = 1'b0;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || (e.at >= 0 && e.at != cyc)) begin
            miscompares++;
            $display("FAIL outputs: got %h at cycle %0d, required %h at cycle %0d", cur, cyc, e.v, e.at);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk_out);
    top_rst = 1'b0;
    push(s(2'd0, 3'b000, NP, 1'b0, 1'b0), -1);
    mon_en = 1'b1;
    repeat (2) @(negedge clk_out);

    // Mode cycling with KEY0
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd2, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd3, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd0, 3'b000, NP, sw, 1'b0), '0);

    // Ignored keys in CLK_VIEW and TS_IDLE
    hit(4'b0010, 0, '0, '0);
    hit(4'b0100, 0, '0, '0);
    hit(4'b1000, 0, '0, '0);
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0100, 0, '0, '0);
    hit(4'b0001, 1, s(2'd2, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd3, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd0, 3'b000, NP, sw, 1'b0), '0);

    // Time-set field select and clock adjust pulses
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd1, 3'b100, NP, sw, 1'b0), '0);
    hit(4'b0100, 2, s(2'd1, 3'b100, CI4, sw, 1'b0), s(2'd1, 3'b100, NP, sw, 1'b0));
    hit(4'b0010, 1, s(2'd1, 3'b010, NP, sw, 1'b0), '0);
    hit(4'b1000, 2, s(2'd1, 3'b010, CD2, sw, 1'b0), s(2'd1, 3'b010, NP, sw, 1'b0));

    // Alarm edit, seconds field, simultaneous keys
    hit(4'b0001, 1, s(2'd2, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd3, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd3, 3'b100, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd3, 3'b010, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd3, 3'b001, NP, sw, 1'b0), '0);
    hit(4'b0100, 2, s(2'd3, 3'b001, AI1, sw, 1'b0), s(2'd3, 3'b001, NP, sw, 1'b0));
    hit(4'b1100, 0, '0, '0);
    hit(4'b1000, 2, s(2'd3, 3'b001, AD1, sw, 1'b0), s(2'd3, 3'b001, NP, sw, 1'b0));
    hit(4'b0011, 1, s(2'd0, 3'b000, NP, sw, 1'b0), '0);

    // Stopwatch run toggle and alarm silence
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd2, 3'b000, NP, sw, 1'b0), '0);
    alarming = 1'b1;
    hit(4'b0010, 2, s(2'd2, 3'b000, NP, sw, 1'b1), s(2'd2, 3'b000, NP, sw, 1'b0));
    hit(4'b0001, 2, s(2'd2, 3'b000, NP, sw, 1'b1), s(2'd2, 3'b000, NP, sw, 1'b0));
    alarming = 1'b0;
    sw = 1'b1;
    hit(4'b0010, 1, s(2'd2, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd3, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0001, 1, s(2'd0, 3'b000, NP, sw, 1'b0), '0);
    alarming = 1'b1;
    hit(4'b0100, 2, s(2'd0, 3'b000, NP, sw, 1'b1), s(2'd0, 3'b000, NP, sw, 1'b0));
    alarming = 1'b0;

    // Idle timeout from TS_MIN: state entered at c+3, forced out 17 edges later
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd1, 3'b100, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd1, 3'b010, NP, sw, 1'b0), '0);
    push(s(2'd0, 3'b000, NP, sw, 1'b0), last_c + 20);
    repeat (20) @(negedge clk_out);

    // Asynchronous reset between edges while an inc pulse is showing
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);
    hit(4'b0010, 1, s(2'd1, 3'b100, NP, sw, 1'b0), '0);
    @(negedge clk_out);
    key_n  = 4'b1011;
    last_c = cyc;
    push(s(2'd1, 3'b100, CI4, sw, 1'b0), last_c + 3);
    push(s(2'd0, 3'b000, NP, 1'b0, 1'b0), last_c + 4);
    @(negedge clk_out);
    key_n = 4'hF;
    repeat (2) @(negedge clk_out);
    #2 top_rst = 1'b1;
    #2 top_rst = 1'b0;
    sw = 1'b0;
    repeat (4) @(negedge clk_out);
    hit(4'b0001, 1, s(2'd1, 3'b000, NP, sw, 1'b0), '0);

    repeat (5) @(negedge clk_out);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_responses: got %0d outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
